// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment reader: code table, blank code, FSM states.
package seg7_pkg;

  // Active-low segment pattern meaning "no data on this digit".
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment codes indexed by the hex nibble they represent (bit0=a ... bit6=g).
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // EMPTY: nothing accepted since reset; SETTLE: counting identical samples;
  // HOLD: the current pattern has already been evaluated.
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational decoder from one active-low seven-segment pattern to a hex nibble.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       is_valid,
  output logic       is_blank
);

  // Search the code table; a pattern is valid only if it matches one entry exactly.
  always_comb begin
    nibble   = 4'd0;
    is_valid = 1'b0;
    is_blank = (pattern == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_TABLE[i]) begin
        nibble   = 4'(i);
        is_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// Reads a two-digit seven-segment display, debounces it and reports accepted bytes.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_hi,
  input  logic [6:0] seg_lo,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       update,
  output logic       delta_inc,
  output logic       delta_other,
  output logic       bad_code,
  output logic [7:0] err_count
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  state_e      state_q, state_d;
  logic [13:0] sample_q, sample_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  value_q, value_d;
  logic        valid_q, valid_d;
  logic        update_q, update_d;
  logic        inc_q, inc_d;
  logic        other_q, other_d;
  logic        bad_q, bad_d;
  logic [7:0]  err_q, err_d;

  logic [3:0]  hi_nibble, lo_nibble;
  logic        hi_valid, lo_valid, hi_blank, lo_blank;
  logic        differ, evaluate, any_bad, any_blank;
  logic [7:0]  new_value;

  seg7_decode u_decode_hi (
    .pattern  (seg_hi),
    .nibble   (hi_nibble),
    .is_valid (hi_valid),
    .is_blank (hi_blank)
  );

  seg7_decode u_decode_lo (
    .pattern  (seg_lo),
    .nibble   (lo_nibble),
    .is_valid (lo_valid),
    .is_blank (lo_blank)
  );

  // Stability tracking, settle/hold sequencing and single-shot evaluation of a settled pattern.
  always_comb begin
    sample_d    = {seg_hi, seg_lo};
    differ      = (sample_d != sample_q);
    state_d     = state_q;
    value_d     = value_q;
    valid_d     = valid_q;
    update_d    = 1'b0;
    inc_d       = 1'b0;
    other_d     = 1'b0;
    bad_d       = bad_q;
    err_d       = err_q;
    evaluate    = 1'b0;
    any_bad     = (!hi_valid && !hi_blank) || (!lo_valid && !lo_blank);
    any_blank   = hi_blank || lo_blank;
    new_value   = {hi_nibble, lo_nibble};

    if (differ) begin
      cnt_d = 8'd1;
    end else if (cnt_q < STABLE_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (differ) begin
      state_d = ST_SETTLE;
    end else if (state_q == ST_SETTLE && cnt_d == STABLE_MAX) begin
      state_d  = ST_HOLD;
      evaluate = 1'b1;
    end

    if (evaluate) begin
      if (any_bad) begin
        bad_d = 1'b1;
        if (err_q != 8'hFF) begin
          err_d = err_q + 8'd1;
        end
      end else if (!any_blank) begin
        bad_d = 1'b0;
        if (!valid_q || new_value != value_q) begin
          update_d = 1'b1;
          inc_d    = valid_q && (new_value == value_q + 8'd1);
          other_d  = valid_q && (new_value != value_q + 8'd1);
          value_d  = new_value;
          valid_d  = 1'b1;
        end
      end
    end
  end

  // Register all state and outputs; reset abandons any settle in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      sample_q <= {SEG_BLANK, SEG_BLANK};
      cnt_q    <= 8'd0;
      value_q  <= 8'd0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      inc_q    <= 1'b0;
      other_q  <= 1'b0;
      bad_q    <= 1'b0;
      err_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      inc_q    <= inc_d;
      other_q  <= other_d;
      bad_q    <= bad_d;
      err_q    <= err_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign update      = update_q;
  assign delta_inc   = inc_q;
  assign delta_other = other_q;
  assign bad_code    = bad_q;
  assign err_count   = err_q;

endmodule
